delay_tap_ctrl: RTL and testbench

Programmable-tap delay-line controller for the inverter/delay cell family. It accepts a tap/invert configuration through a valid/ready handshake and flushes the internal shift chain on every new configuration. It withholds output until the chain carries only post-configuration samples, then streams the delayed, optionally inverted input. It sits between the configuration bus and the delayed-signal consumers, replacing fixed-depth delay cells where the delay must change at run time.

---
 rtl/delay_pkg.sv | 17 +
 rtl/delay_chain.sv | 37 +++
 rtl/delay_tap_ctrl.sv | 120 ++++++++++++
 tb/tb_delay_tap_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared types and helpers for the programmable-tap delay-line controller.
package delay_pkg;

  localparam int unsigned DEPTH_DEFAULT = 24;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StRun
  } state_e;

  // Out-of-range taps saturate at the last stage rather than wrapping.
  function automatic int unsigned clamp_tap(input int unsigned tap, input int unsigned depth);
    return (tap >= depth) ? depth - 1 : tap;
  endfunction

endpackage

// File: rtl/delay_chain.sv
// DEPTH-stage shift register with synchronous clear and a combinational tap mux.
module delay_chain
  import delay_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned TAP_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             din,
  input  logic [TAP_W-1:0] tap_sel,
  output logic             tap_out
);

  logic [DEPTH-1:0] chain_q;
  logic [DEPTH-1:0] chain_d;

  // Clear wins over shift so the sample present on the clear edge is dropped.
  always_comb begin
    chain_d = {chain_q[DEPTH-2:0], din};
    if (clr) begin
      chain_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign tap_out = chain_q[tap_sel];

endmodule

// File: rtl/delay_tap_ctrl.sv
// Delay-line controller: accepts tap/invert configs, flushes the chain, then streams
// the delayed and optionally inverted input once only fresh samples can reach the tap.
module delay_tap_ctrl
  import delay_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned TAP_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             VPWR,
  input  logic             VGND,
  input  logic             A,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [TAP_W-1:0] cfg_tap,
  input  logic             cfg_invert,
  output logic             Y,
  output logic             y_valid,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  state_e             state_q, state_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic               inv_q, inv_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               y_q, y_d;
  logic               yv_q, yv_d;
  logic               chain_clr;
  logic               tap_bit;
  logic               accept;
  logic               unused_pwr;

  // Power pins carry no logic function.
  assign unused_pwr = VPWR ^ VGND;

  delay_chain #(
    .DEPTH (DEPTH),
    .TAP_W (TAP_W)
  ) u_chain (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (chain_clr),
    .din     (A),
    .tap_sel (tap_q),
    .tap_out (tap_bit)
  );

  assign busy      = (state_q == StFill);
  assign cfg_ready = !busy;
  assign accept    = cfg_valid && cfg_ready;

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    inv_d     = inv_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    yv_d      = yv_q;
    chain_clr = 1'b0;

    unique case (state_q)
      StIdle: begin
        y_d  = 1'b0;
        yv_d = 1'b0;
      end
      StFill: begin
        if (cnt_q == '0) begin
          state_d = StRun;
          y_d     = tap_bit ^ inv_q;
          yv_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          y_d   = 1'b0;
          yv_d  = 1'b0;
        end
      end
      StRun: begin
        y_d  = tap_bit ^ inv_q;
        yv_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Accept only happens in IDLE/RUN; cnt covers tap+1 shifts so the tap sees a fresh sample.
    if (accept) begin
      tap_d     = TAP_W'(clamp_tap(32'(cfg_tap), DEPTH));
      inv_d     = cfg_invert;
      cnt_d     = CNT_W'(tap_d) + CNT_W'(1);
      chain_clr = 1'b1;
      y_d       = 1'b0;
      yv_d      = 1'b0;
      state_d   = StFill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tap_q   <= '0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
      y_q     <= 1'b0;
      yv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
    end
  end

  assign Y       = y_q;
  assign y_valid = yv_q;

endmodule

// File: tb/tb_delay_tap_ctrl.sv
// Directed testbench for delay_tap_ctrl; compares {Y, y_valid, cfg_ready, busy} per edge.
module tb_delay_tap_ctrl;

  localparam int unsigned DEPTH = 24;
  localparam int unsigned TAP_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             VPWR = 1'b1;
  logic             VGND = 1'b0;
  logic             A = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [TAP_W-1:0] cfg_tap = '0;
  logic             cfg_invert = 1'b0;
  logic             Y;
  logic             y_valid;
  logic             busy;

  int checks = 0;
  int errors = 0;

  delay_tap_ctrl #(
    .DEPTH (DEPTH),
    .TAP_W (TAP_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .VPWR       (VPWR),
    .VGND       (VGND),
    .A          (A),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_tap    (cfg_tap),
    .cfg_invert (cfg_invert),
    .Y          (Y),
    .y_valid    (y_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs changed afterwards are sampled at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a config before the next edge and returns just after the accept edge.
  task automatic do_accept(input logic [TAP_W-1:0] tap, input logic inv);
    cfg_valid  = 1'b1;
    cfg_tap    = tap;
    cfg_invert = inv;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    exp = 4'b0010;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      A = ~A;
      step();
      checks++;
      if ({Y, y_valid, cfg_ready, busy} !== exp) begin
        errors++;
        $display("FAIL reset_hold k=%0d got=%b exp=%b", k, {Y, y_valid, cfg_ready, busy}, exp);
      end
    end
    #3 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      A = ~A;
      step();
      checks++;
      if ({Y, y_valid, cfg_ready, busy} !== exp) begin
        errors++;
        $display("FAIL reset_release k=%0d got=%b exp=%b", k, {Y, y_valid, cfg_ready, busy}, exp);
      end
    end
    A = 1'b0;
  endtask

  // Tap 4: y_valid at m+6, pulse sampled at m+10 shows on Y only after m+15.
  task automatic test_tap4();
    logic [3:0] exp;
    do_accept(TAP_W'(4), 1'b0);
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 9) A = 1'b1;
      if (k == 10) A = 1'b0;
      exp = {(k == 15), (k >= 6), (k >= 6), (k < 6)};
      checks++;
      if ({Y, y_valid, cfg_ready, busy} !== exp) begin
        errors++;
        $display("FAIL tap4 k=%0d got=%b exp=%b", k, {Y, y_valid, cfg_ready, busy}, exp);
      end
    end
  endtask

  // Tap 0 inverted: y_valid at m+2 with Y=1; pulse sampled at m+4 gives Y=0 after m+5.
  task automatic test_tap0_inv();
    logic [3:0] exp;
    A = 1'b0;
    do_accept(TAP_W'(0), 1'b1);
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 3) A = 1'b1;
      if (k == 4) A = 1'b0;
      exp = {(k >= 2) && (k != 5), (k >= 2), (k >= 2), (k < 2)};
      checks++;
      if ({Y, y_valid, cfg_ready, busy} !== exp) begin
        errors++;
        $display("FAIL tap0_inv k=%0d got=%b exp=%b", k, {Y, y_valid, cfg_ready, busy}, exp);
      end
    end
  endtask

  // Run at tap 10 with A=1, then retap to 2; the A=1 sample at the accept edge must be dropped.
  task automatic test_reconfig();
    logic [3:0] exp;
    A = 1'b1;
    do_accept(TAP_W'(10), 1'b0);
    for (int k = 1; k <= 14; k++) step();
    exp = 4'b1110;
    checks++;
    if ({Y, y_valid, cfg_ready, busy} !== exp) begin
      errors++;
      $display("FAIL reconfig_run got=%b exp=%b", {Y, y_valid, cfg_ready, busy}, exp);
    end
    do_accept(TAP_W'(2), 1'b0);
    A = 1'b0;
    exp = 4'b0001;
    checks++;
    if ({Y, y_valid, cfg_ready, busy} !== exp) begin
      errors++;
      $display("FAIL reconfig_accept got=%b exp=%b", {Y, y_valid, cfg_ready, busy}, exp);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) A = 1'b1;
      exp = {(k >= 5), (k >= 4), (k >= 4), (k < 4)};
      checks++;
      if ({Y, y_valid, cfg_ready, busy} !== exp) begin
        errors++;
        $display("FAIL reconfig k=%0d got=%b exp=%b", k, {Y, y_valid, cfg_ready, busy}, exp);
      end
    end
  endtask

  // Request held through FILL is taken on the first RUN edge; tap 30 clamps to 23.
  task automatic test_fill_block();
    logic [3:0] exp;
    A = 1'b0;
    do_accept(TAP_W'(3), 1'b0);
    cfg_valid = 1'b1;
    cfg_tap   = TAP_W'(7);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 6) cfg_valid = 1'b0;
      if (k <= 4) exp = 4'b0001;
      else if (k == 5) exp = 4'b0110;
      else if (k < 15) exp = 4'b0001;
      else exp = 4'b0110;
      checks++;
      if ({Y, y_valid, cfg_ready, busy} !== exp) begin
        errors++;
        $display("FAIL fill_block k=%0d got=%b exp=%b", k, {Y, y_valid, cfg_ready, busy}, exp);
      end
    end
    do_accept(TAP_W'(30), 1'b0);
    A = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      step();
      if (k == 1) A = 1'b0;
      if (k >= 24) begin
        exp = {(k == 25), (k >= 25), (k >= 25), (k < 25)};
        checks++;
        if ({Y, y_valid, cfg_ready, busy} !== exp) begin
          errors++;
          $display("FAIL clamp k=%0d got=%b exp=%b", k, {Y, y_valid, cfg_ready, busy}, exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [3:0] exp;
    A = 1'b1;
    do_accept(TAP_W'(8), 1'b1);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    exp = 4'b0010;
    checks++;
    if ({Y, y_valid, cfg_ready, busy} !== exp) begin
      errors++;
      $display("FAIL reset_mid_fill_async got=%b exp=%b", {Y, y_valid, cfg_ready, busy}, exp);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if ({Y, y_valid, cfg_ready, busy} !== exp) begin
        errors++;
        $display("FAIL reset_mid_fill_idle k=%0d got=%b exp=%b", k,
                 {Y, y_valid, cfg_ready, busy}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tap4();
    test_tap0_inv();
    test_reconfig();
    test_fill_block();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
